// File: rtl/seg7_to_bcd_scan.sv
// Recovers BCD digits from a multiplexed 7-segment bus and assembles them into
// full frames of N_DIGITS digits, handed out on a valid/ready interface.
module seg7_to_bcd_scan #(
   parameter int N_DIGITS      = 4,
   parameter int STABLE_CYCLES = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_DIGITS-1:0]     dig_sel,
   input  logic [6:0]              seg_in,
   input  logic                    frame_ready,
   output logic                    frame_valid,
   output logic [4*N_DIGITS-1:0]   frame_bcd,
   output logic [N_DIGITS-1:0]     frame_dash,
   output logic                    err_sticky,
   input  logic                    err_clr
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

   logic [N_DIGITS-1:0]   s_sel, p_sel;
   logic [6:0]            s_seg, p_seg;
   logic [CW-1:0]         cnt, cnt_nxt;
   logic [N_DIGITS-1:0]   seen, seen_nxt;
   logic [4*N_DIGITS-1:0] shadow_bcd;
   logic [N_DIGITS-1:0]   shadow_dash;

   logic                  sel_onehot, sel_multi, same, capture;
   logic [3:0]            dec_nib;
   logic                  dec_dash, dec_bad;
   logic                  load, err_set;

   // Input sample plus one-cycle history used by the stability counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_sel <= '0;
         s_seg <= '0;
         p_sel <= '0;
         p_seg <= '0;
         cnt   <= '0;
      end else begin
         s_sel <= dig_sel;
         s_seg <= seg_in;
         p_sel <= s_sel;
         p_seg <= s_seg;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      sel_onehot = ($countones(s_sel) == 1);
      sel_multi  = ($countones(s_sel) > 1);
      same       = (s_sel == p_sel) && (s_seg == p_seg);
      cnt_nxt    = '0;
      if (sel_onehot) begin
         if (!same)
            cnt_nxt = CW'(1);
         else if (cnt == CNT_MAX)
            cnt_nxt = cnt;
         else
            cnt_nxt = cnt + CW'(1);
      end
      // Fire only on the edge the count arrives at the threshold; a change
      // restarts the window, which also covers a threshold of one.
      capture = sel_onehot && (cnt_nxt == CNT_MAX) && ((cnt != CNT_MAX) || !same);
   end

   // Glyph table shared with the BCD-to-7-segment encoder, {a,b,c,d,e,f,g}.
   always_comb begin
      dec_nib  = 4'hE;
      dec_dash = 1'b0;
      dec_bad  = 1'b0;
      case (s_seg)
         7'b1111110: dec_nib = 4'd0;
         7'b0110000: dec_nib = 4'd1;
         7'b1101101: dec_nib = 4'd2;
         7'b1111001: dec_nib = 4'd3;
         7'b0110011: dec_nib = 4'd4;
         7'b1011011: dec_nib = 4'd5;
         7'b1011111: dec_nib = 4'd6;
         7'b1110000: dec_nib = 4'd7;
         7'b1111111: dec_nib = 4'd8;
         7'b1111011: dec_nib = 4'd9;
         7'b0000001: begin
            dec_nib  = 4'hF;
            dec_dash = 1'b1;
         end
         default: begin
            dec_nib = 4'hE;
            dec_bad = 1'b1;
         end
      endcase
   end

   // Handshake: a frame moves on every cycle with frame_valid && frame_ready;
   // while valid is high and ready low the frame outputs do not change, and a
   // new frame may load on the same edge as a transfer.
   always_comb begin
      load     = (&seen) && (!frame_valid || frame_ready);
      seen_nxt = load ? '0 : seen;
      if (capture)
         seen_nxt = seen_nxt | s_sel;
      err_set  = sel_multi || (capture && dec_bad);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen        <= '0;
         shadow_bcd  <= '0;
         shadow_dash <= '0;
      end else begin
         seen <= seen_nxt;
         for (int k = 0; k < N_DIGITS; k++) begin
            if (capture && s_sel[k]) begin
               shadow_bcd[4*k +: 4] <= dec_nib;
               shadow_dash[k]       <= dec_dash;
            end
         end
      end
   end

   // Load reads the shadow before any same-edge capture lands in it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_valid <= 1'b0;
         frame_bcd   <= '0;
         frame_dash  <= '0;
      end else if (load) begin
         frame_valid <= 1'b1;
         frame_bcd   <= shadow_bcd;
         frame_dash  <= shadow_dash;
      end else if (frame_valid && frame_ready) begin
         frame_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_sticky <= 1'b0;
      else if (err_set)
         err_sticky <= 1'b1;
      else if (err_clr)
         err_sticky <= 1'b0;
   end

endmodule

// File: tb/tb_seg7_to_bcd_scan.sv
// Directed bench for seg7_to_bcd_scan: scans hand-built frames and checks
// delivered frames against an expected queue plus direct output checks.
module tb_seg7_to_bcd_scan;

   localparam int N = 4;
   localparam int W = 5 * N;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   dig_sel;
   logic [6:0]     seg_in;
   logic           frame_ready;
   logic           frame_valid;
   logic [4*N-1:0] frame_bcd;
   logic [N-1:0]   frame_dash;
   logic           err_sticky;
   logic           err_clr;

   int n_tests  = 0;
   int n_fail   = 0;
   int xfer_cnt = 0;
   int valid_hi = 0;
   logic [W-1:0] exp_q[$];

   always #5 clk = ~clk;

   seg7_to_bcd_scan #(.N_DIGITS(N), .STABLE_CYCLES(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .dig_sel     (dig_sel),
      .seg_in      (seg_in),
      .frame_ready (frame_ready),
      .frame_valid (frame_valid),
      .frame_bcd   (frame_bcd),
      .frame_dash  (frame_dash),
      .err_sticky  (err_sticky),
      .err_clr     (err_clr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // 0..9 digits, 10 = dash, anything else = an undefined pattern
   function automatic logic [6:0] glyph(input int d);
      case (d)
         0:  return 7'b1111110;
         1:  return 7'b0110000;
         2:  return 7'b1101101;
         3:  return 7'b1111001;
         4:  return 7'b0110011;
         5:  return 7'b1011011;
         6:  return 7'b1011111;
         7:  return 7'b1110000;
         8:  return 7'b1111111;
         9:  return 7'b1111011;
         10: return 7'b0000001;
         default: return 7'b1010101;
      endcase
   endfunction

   // scoreboard: every transfer must match the head of exp_q
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (frame_valid) valid_hi++;
         if (frame_valid && frame_ready) begin
            check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0)
               check("frame", 32'({frame_dash, frame_bcd}), 32'(exp_q.pop_front()));
            xfer_cnt++;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic scan(input int k, input logic [6:0] seg, input int hold);
      dig_sel = N'(1 << k);
      seg_in  = seg;
      step(hold);
   endtask

   task automatic idle(input int n);
      dig_sel = '0;
      step(n);
   endtask

   task automatic scan_frame(input int d0, input int d1, input int d2, input int d3);
      scan(0, glyph(d0), 4);
      scan(1, glyph(d1), 4);
      scan(2, glyph(d2), 4);
      scan(3, glyph(d3), 4);
   endtask

   task automatic wait_xfers(input int n);
      int t;
      t = 0;
      while (xfer_cnt < n && t < 80) begin
         step(1);
         t++;
      end
      step(3);
      check("xfer_count", 32'(xfer_cnt), 32'(n));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int v0;
      rst_n       = 1'b0;
      dig_sel     = '0;
      seg_in      = '0;
      frame_ready = 1'b0;
      err_clr     = 1'b0;

      // reset with random activity on the inputs
      repeat (6) begin
         @(posedge clk);
         #1;
         dig_sel     = N'($urandom_range(0, 15));
         seg_in      = 7'($urandom_range(0, 127));
         frame_ready = 1'($urandom_range(0, 1));
         err_clr     = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      check("rst_valid", 32'(frame_valid), 32'd0);
      check("rst_bcd",   32'(frame_bcd),   32'd0);
      check("rst_dash",  32'(frame_dash),  32'd0);
      check("rst_err",   32'(err_sticky),  32'd0);
      @(posedge clk);
      #1;
      rst_n       = 1'b1;
      dig_sel     = '0;
      seg_in      = '0;
      err_clr     = 1'b0;
      frame_ready = 1'b1;
      step(2);

      // basic frame 1,2,3,4
      v0 = valid_hi;
      exp_q.push_back({4'b0000, 16'h4321});
      scan_frame(1, 2, 3, 4);
      idle(4);
      wait_xfers(1);
      check("valid_one_cycle", 32'(valid_hi - v0), 32'd1);

      // glitch: two-cycle hold must not capture, three-cycle hold must
      scan(0, glyph(1), 2);
      idle(2);
      scan(1, glyph(2), 4);
      scan(2, glyph(3), 4);
      scan(3, glyph(4), 4);
      idle(6);
      check("glitch_no_xfer",  32'(xfer_cnt),    32'd1);
      check("glitch_no_valid", 32'(frame_valid), 32'd0);
      exp_q.push_back({4'b0000, 16'h4325});
      scan(0, glyph(5), 3);
      idle(4);
      wait_xfers(2);

      // dash and error patterns
      exp_q.push_back({4'b0100, 16'h6F80});
      scan_frame(0, 8, 10, 6);
      idle(4);
      wait_xfers(3);
      check("err_after_dash", 32'(err_sticky), 32'd0);
      exp_q.push_back({4'b0000, 16'h92E7});
      scan_frame(7, 11, 2, 9);
      idle(4);
      wait_xfers(4);
      check("err_after_bad", 32'(err_sticky), 32'd1);
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      check("err_clr", 32'(err_sticky), 32'd0);
      // bad pattern captured on the same edge err_clr is high
      dig_sel = 4'b0010;
      seg_in  = glyph(11);
      step(3);
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      check("err_set_over_clr", 32'(err_sticky), 32'd1);
      exp_q.push_back({4'b0000, 16'h05E3});
      scan(0, glyph(3), 4);
      scan(2, glyph(5), 4);
      scan(3, glyph(0), 4);
      idle(4);
      wait_xfers(5);
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      check("err_clr_2", 32'(err_sticky), 32'd0);

      // backpressure: held frame stays put while scanning continues
      frame_ready = 1'b0;
      scan_frame(1, 2, 3, 4);
      scan_frame(5, 6, 7, 8);
      idle(4);
      check("bp_valid",   32'(frame_valid), 32'd1);
      check("bp_hold",    32'(frame_bcd),   32'h4321);
      check("bp_no_xfer", 32'(xfer_cnt),    32'd5);
      exp_q.push_back({4'b0000, 16'h4321});
      exp_q.push_back({4'b0000, 16'h8765});
      frame_ready = 1'b1;
      step(1);
      check("bp_next_valid", 32'(frame_valid), 32'd1);
      check("bp_next_bcd",   32'(frame_bcd),   32'h8765);
      wait_xfers(7);
      check("bp_valid_drop", 32'(frame_valid), 32'd0);

      // mid-scan reset discards the partial frame
      scan(0, glyph(9), 4);
      scan(1, glyph(9), 4);
      dig_sel = '0;
      rst_n   = 1'b0;
      step(1);
      rst_n = 1'b1;
      step(1);
      scan(2, glyph(7), 4);
      scan(3, glyph(1), 4);
      idle(5);
      check("rst_mid_no_valid", 32'(frame_valid), 32'd0);
      check("rst_mid_no_xfer",  32'(xfer_cnt),    32'd7);

      // multi-hot strobe: error, no capture
      check("err_before_multi", 32'(err_sticky), 32'd0);
      dig_sel = 4'b0011;
      seg_in  = glyph(0);
      step(5);
      idle(2);
      check("multi_err",      32'(err_sticky),  32'd1);
      check("multi_no_valid", 32'(frame_valid), 32'd0);
      scan(1, glyph(6), 4);
      idle(4);
      check("multi_no_capture", 32'(frame_valid), 32'd0);
      check("multi_no_xfer",    32'(xfer_cnt),    32'd7);
      exp_q.push_back({4'b0000, 16'h1762});
      scan(0, glyph(2), 4);
      idle(4);
      wait_xfers(8);

      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
